// File: rtl/branch_predictor.sv
// Fetch-side branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from registered state; EX-stage resolutions update the table at the clock edge.
module branch_predictor #(
   parameter int          IDX_W     = 4,
   parameter logic [1:0]  CTR_INIT  = 2'b01,
   parameter logic [1:0]  CTR_ALLOC = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 32 - IDX_W - 2;

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];

   logic [IDX_W-1:0]  idx_f;
   logic [TAG_W-1:0]  tag_f;
   logic [IDX_W-1:0]  idx_u;
   logic [TAG_W-1:0]  tag_u;
   logic              hit_f;
   logic              hit_u;
   logic              unused_pc_lsbs;

   // Byte offset within the word carries no branch identity.
   assign unused_pc_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

   assign idx_f = pc_f[IDX_W+1:2];
   assign tag_f = pc_f[31:IDX_W+2];
   assign idx_u = upd_pc[IDX_W+1:2];
   assign tag_u = upd_pc[31:IDX_W+2];

   assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_taken  = hit_f && ctr_q[idx_f][1];
   assign pred_target = pred_taken ? target_q[idx_f] : pc_f + 32'd4;

   assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

   assign mispredict  = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
   assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_INIT;
         end
      end else if (upd_valid) begin
         if (hit_u) begin
            if (upd_taken) begin
               if (ctr_q[idx_u] != 2'b11) ctr_q[idx_u] <= ctr_q[idx_u] + 2'd1;
               target_q[idx_u] <= upd_target;
            end else if (ctr_q[idx_u] != 2'b00) begin
               ctr_q[idx_u] <= ctr_q[idx_u] - 2'd1;
            end
         end else if (upd_taken) begin
            // Taken branch that misses evicts whatever aliases at this index.
            valid_q[idx_u]  <= 1'b1;
            tag_q[idx_u]    <= tag_u;
            target_q[idx_u] <= upd_target;
            ctr_q[idx_u]    <= CTR_ALLOC;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, update, saturation, alias, mispredict and reset.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] pc_f;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   branch_predictor dut (
      .clk             (clk),
      .rst             (rst),
      .pc_f            (pc_f),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                      input logic ptaken, input logic [31:0] ptgt);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_taken       = taken;
      upd_target      = tgt;
      upd_pred_taken  = ptaken;
      upd_pred_target = ptgt;
   endtask

   task automatic idle();
      upd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pc_f = 32'h40;
      upd_valid = 1'b0;
      upd_pc = 32'h40;
      upd_taken = 1'b0;
      upd_target = 32'h0;
      upd_pred_taken = 1'b0;
      upd_pred_target = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, 32'h44);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      chk("rst_redirect", redirect_pc, 32'h44);

      // First taken resolution allocates; same-cycle lookup still sees the empty entry.
      tick();
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      #1;
      chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
      chk("alloc_redirect", redirect_pc, 32'h100);
      chk("alloc_same_cycle_taken", {31'd0, pred_taken}, 32'd0);
      tick();
      idle();
      #1;
      chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("alloc_pred_target", pred_target, 32'h100);

      // Two correct taken updates: ctr 10 -> 11 -> 11.
      upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      #1;
      chk("correct_no_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      tick();
      idle();
      #1;
      chk("sat_hi_taken", {31'd0, pred_taken}, 32'd1);

      // Three not-taken: 11 -> 10 -> 01 -> 00.
      upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      #1;
      chk("nt_mispredict", {31'd0, mispredict}, 32'd1);
      chk("nt_redirect", redirect_pc, 32'h44);
      tick();
      idle();
      #1;
      chk("ctr10_still_taken", {31'd0, pred_taken}, 32'd1);
      upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      tick();
      upd(32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
      tick();
      idle();
      #1;
      chk("ctr00_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("ctr00_pred_target", pred_target, 32'h44);

      // Fourth not-taken must hold 00: one taken update then reaches only 01.
      upd(32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
      tick();
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      tick();
      idle();
      #1;
      chk("sat_lo_hold", {31'd0, pred_taken}, 32'd0);
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      tick();
      idle();
      #1;
      chk("ctr10_again_taken", {31'd0, pred_taken}, 32'd1);

      // Target change on a hit.
      upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
      #1;
      chk("tgt_mispredict", {31'd0, mispredict}, 32'd1);
      chk("tgt_redirect", redirect_pc, 32'h180);
      tick();
      idle();
      #1;
      chk("tgt_updated", pred_target, 32'h180);
      upd(32'h40, 1'b0, 32'h180, 1'b1, 32'h180);
      #1;
      chk("tgt_nt_redirect", redirect_pc, 32'h44);
      tick();
      idle();

      // Alias: 0x80 shares index 0 with 0x40.
      upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      tick();
      idle();
      #1;
      chk("alias_old_miss_taken", {31'd0, pred_taken}, 32'd0);
      chk("alias_old_miss_target", pred_target, 32'h44);
      pc_f = 32'h80;
      #1;
      chk("alias_new_hit_taken", {31'd0, pred_taken}, 32'd1);
      chk("alias_new_hit_target", pred_target, 32'h200);
      pc_f = 32'h83;
      #1;
      chk("lsb_ignored_target", pred_target, 32'h200);
      pc_f = 32'h80;

      // Same-cycle update and lookup: ctr 10 -> 01, lookup shows old value.
      upd(32'h80, 1'b0, 32'h200, 1'b1, 32'h200);
      #1;
      chk("same_cycle_old_taken", {31'd0, pred_taken}, 32'd1);
      chk("same_cycle_old_target", pred_target, 32'h200);
      tick();
      idle();
      #1;
      chk("same_cycle_new_taken", {31'd0, pred_taken}, 32'd0);
      chk("same_cycle_new_target", pred_target, 32'h84);

      // 32-bit wrap of fall-through.
      pc_f = 32'hFFFF_FFFC;
      upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("wrap_pred_target", pred_target, 32'h0);
      chk("wrap_redirect", redirect_pc, 32'h0);
      chk("wrap_no_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      idle();

      // Re-arm 0x80 (01 -> 10), then async reset mid-cycle.
      pc_f = 32'h80;
      upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      tick();
      idle();
      #1;
      chk("prereset_taken", {31'd0, pred_taken}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_taken", {31'd0, pred_taken}, 32'd0);
      chk("async_rst_target", pred_target, 32'h84);
      tick();
      rst = 1'b0;
      tick();
      #1;
      chk("post_rst_0x80_miss", {31'd0, pred_taken}, 32'd0);
      pc_f = 32'h40;
      #1;
      chk("post_rst_0x40_target", pred_target, 32'h44);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
